charge_display_driver: RTL
==========================

Name: charge_display_driver

Overview:
- Downstream consumer of the charging-machine controller's `money` and `restime` outputs (8-bit binary; 8'hff means blank/idle).
- Converts each value to two decimal digits with a sequential double-dabble engine.
- Drives a 4-digit multiplexed 7-segment display: money on the left pair, remaining time on the right pair.
- Runs on the same system clock as the controller (25 kHz nominal).

Parameters:
- SCAN_DIV, 25, clock cycles each digit stays selected; valid range 2..255 (25 gives 1 ms per digit at 25 kHz).
- BLANK_CODE, 8'hff, input value that is displayed as two blank digits.

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  asynchronous, active-low reset.
- money  input  8  amount from the controller, binary.
- restime  input  8  remaining charge time from the controller, binary.
- seg  output  7  segment drive, active-high, bit order {g,f,e,d,c,b,a}.
- an  output  4  digit enable, active-low, one-hot; an[3]=money tens, an[2]=money ones, an[1]=restime tens, an[0]=restime ones.
- dp  output  1  decimal point, active-high.
- busy  output  1  high while a conversion is in progress.

Behaviour:
- One clock; reset is asynchronous and active-low (nRST), all flops clear immediately on nRST=0.
- Reset values:
  - seg=7'h00, an=4'b1111, dp=0, busy=0.
  - FSM=IDLE; scan index=0; prescaler=0.
  - Snapshot registers=BLANK_CODE for both values; all four digit registers=BLANK.
- Conversion FSM has three states: IDLE, CONV, LOAD.
  - IDLE: if {money,restime} != snapshot, latch both inputs into the snapshot and into shift registers, set the iteration counter to 0, go to CONV; otherwise stay.
  - CONV: exactly 8 cycles of double dabble, both values in parallel. Each cycle, every BCD nibble >=5 gets +3, then the register shifts left by 1. busy=1 in CONV and LOAD.
  - LOAD: one cycle; write the digit registers from the BCD results, then go to IDLE.
  - Latency: input change sampled at edge k; digit registers updated at edge k+9.
  - Input changes during CONV/LOAD are ignored; they are re-detected in the first IDLE cycle after LOAD.
- Digit mapping, applied per value at LOAD:
  - Value == BLANK_CODE: both digits BLANK.
  - Value 100..254: both digits DASH.
  - Value 0..9: tens digit BLANK (leading-zero suppression), ones digit = value. 0 shows " 0".
  - Value 10..99: tens and ones are the decimal digits.
- Segment codes: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, DASH=40, BLANK=00 (hex).
- Scan:
  - Prescaler counts 0..SCAN_DIV-1. At the terminal count it wraps to 0 and the index advances 0→1→2→3→0.
  - Index i selects digit 3-i: an = ~(4'b1000 >> i).
  - seg and dp are registered; they update in the same cycle as an, so there is no mixed-digit cycle.
  - The first selection after reset is an=4'b0111, driven on the first edge after nRST deasserts.
- dp: high only while an[2] is selected and money is not BLANK_CODE (separates money from time).
- Simultaneous events: a scan advance and a LOAD on the same edge is legal. The newly selected digit shows the new value immediately.
- Reset mid-conversion: returns to IDLE with blank digits. The snapshot is BLANK_CODE, so non-blank inputs reconvert right after reset.

Test Plan:
- Reset with money=restime=8'hff, SCAN_DIV=4 → busy stays 0; seg=00 on all digits; an cycles 0111,1011,1101,1110 every 4 clocks; dp=0.
- money 8'hff→20, restime→40 at edge k → busy high from k to k+9; digits "20","40" visible from k+9; seg=5B under an=0111, 3F under 1011, 66 under 1101, 3F under 1110; dp=1 with 1011.
- money=5, restime=9 → an[3] seg=00, an[2] seg=6D, an[1] seg=00, an[0] seg=6F; money=0 → an[2] seg=3F.
- money=150, restime=255 → money digits 40,40 (dash); restime digits 00,00 (blank); dp=1.
- restime changed 40→39 at k+3 during a conversion → 39 not shown at k+9; second conversion starts at k+10; 39 shown at k+19.
- nRST pulsed low at CONV cycle 4 → outputs return to reset values asynchronously; after release with money=12, restime=24, "12","24" appear 9 edges after the first IDLE sample.

Source files
------------

// File: rtl/charge_display_driver_if.sv
// Display driver bus: controller values in, multiplexed 7-segment drive out.
// The driver uses the slave modport; the controller side uses master.
interface charge_display_driver_if;
    logic [7:0] money;
    logic [7:0] restime;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic       busy;

    modport master (
        output money, restime,
        input  seg, an, dp, busy
    );

    modport slave (
        input  money, restime,
        output seg, an, dp, busy
    );
endinterface

// File: rtl/charge_display_driver.sv
// Converts money/restime to two decimal digits each (sequential double dabble)
// and scans them onto a 4-digit multiplexed 7-segment display.
module charge_display_driver #(
    parameter int         SCAN_DIV   = 25,
    parameter logic [7:0] BLANK_CODE = 8'hff
) (
    input logic                    CLK,
    input logic                    nRST,
    charge_display_driver_if.slave bus
);

    localparam logic [3:0] DG_DASH  = 4'ha;
    localparam logic [3:0] DG_BLANK = 4'hf;
    localparam logic [7:0] PRE_LAST = 8'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        LOAD
    } state_t;

    state_t          state;
    logic [7:0]      snap_m;
    logic [7:0]      snap_r;
    logic [19:0]     sh_m;
    logic [19:0]     sh_r;
    logic [2:0]      iter;
    logic            busy_q;

    // dig[3]=money tens, dig[2]=money ones, dig[1]=time tens, dig[0]=time ones
    logic [3:0][3:0] dig;
    logic [3:0][3:0] dig_nxt;

    logic [7:0]      pre;
    logic [1:0]      idx;
    logic [1:0]      idx_nxt;

    logic [6:0]      seg_q;
    logic [3:0]      an_q;
    logic            dp_q;

    // One double-dabble step: +3 on every BCD nibble >= 5, then shift left.
    function automatic logic [19:0] dabble(input logic [19:0] x);
        logic [19:0] y;
        y = x;
        for (int n = 0; n < 3; n++) begin
            if (y[8+4*n +: 4] >= 4'd5)
                y[8+4*n +: 4] = y[8+4*n +: 4] + 4'd3;
        end
        return {y[18:0], 1'b0};
    endfunction

    // Turn a converted value into {tens, ones} display digits.
    function automatic logic [7:0] map_pair(
        input logic [7:0]  v,
        input logic [11:0] bcd
    );
        logic [7:0] r;
        if (v == BLANK_CODE)
            r = {DG_BLANK, DG_BLANK};
        else if (v >= 8'd100)
            r = {DG_DASH, DG_DASH};
        else if (v < 8'd10)
            r = {DG_BLANK, bcd[3:0]};
        else
            r = bcd[7:0];
        return r;
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3f;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5b;
            4'd3:    s = 7'h4f;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6d;
            4'd6:    s = 7'h7d;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7f;
            4'd9:    s = 7'h6f;
            DG_DASH: s = 7'h40;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Conversion FSM: detect input change, 8 dabble cycles, one load cycle.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            snap_m <= BLANK_CODE;
            snap_r <= BLANK_CODE;
            sh_m   <= '0;
            sh_r   <= '0;
            iter   <= '0;
            busy_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if ({bus.money, bus.restime} != {snap_m, snap_r}) begin
                        snap_m <= bus.money;
                        snap_r <= bus.restime;
                        sh_m   <= {12'd0, bus.money};
                        sh_r   <= {12'd0, bus.restime};
                        iter   <= '0;
                        busy_q <= 1'b1;
                        state  <= CONV;
                    end
                end
                CONV: begin
                    sh_m <= dabble(sh_m);
                    sh_r <= dabble(sh_r);
                    iter <= iter + 3'd1;
                    if (iter == 3'd7)
                        state <= LOAD;
                end
                LOAD: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Digit values as they will be after this edge (LOAD writes new ones).
    always_comb begin
        dig_nxt = dig;
        if (state == LOAD) begin
            dig_nxt[3:2] = map_pair(snap_m, sh_m[19:8]);
            dig_nxt[1:0] = map_pair(snap_r, sh_r[19:8]);
        end
    end

    // Digit registers hold the last completed conversion.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            dig <= {4{DG_BLANK}};
        else
            dig <= dig_nxt;
    end

    // Scan index after this edge; advances on prescaler terminal count.
    always_comb begin
        idx_nxt = idx;
        if (pre == PRE_LAST)
            idx_nxt = idx + 2'd1;
    end

    // Prescaler and scan index.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pre <= '0;
            idx <= '0;
        end else begin
            pre <= (pre == PRE_LAST) ? 8'd0 : pre + 8'd1;
            idx <= idx_nxt;
        end
    end

    // an, seg and dp all follow the next index so they switch together.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            an_q  <= 4'b1111;
            seg_q <= 7'h00;
            dp_q  <= 1'b0;
        end else begin
            an_q  <= ~(4'b1000 >> idx_nxt);
            seg_q <= seg_code(dig_nxt[~idx_nxt]);
            dp_q  <= (idx_nxt == 2'd1) && (dig_nxt[2] != DG_BLANK);
        end
    end

    assign bus.seg  = seg_q;
    assign bus.an   = an_q;
    assign bus.dp   = dp_q;
    assign bus.busy = busy_q;

endmodule
